// File: rtl/seq_divider16.sv
// seq_divider16: sequential restoring divider, 2*WIDTH / WIDTH -> WIDTH quotient + WIDTH remainder.
// The divider produces one quotient bit per clock. A request is taken only in idle. Results and
// flags are held until a later request finishes.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   start        request, sampled only while idle
//   dividend     2*WIDTH-bit dividend, sampled on the accepting edge
//   divisor      WIDTH-bit divisor, sampled on the accepting edge
//   busy         high whenever the divider is not idle
//   done         one-cycle pulse: results and flags are valid
//   quotient     result, held until the next request completes
//   remainder    result, held until the next request completes
//   div_by_zero  divisor was zero (held like the results)
//   overflow     quotient not representable in WIDTH bits (held)
//
// Configuration macro DIV_SIGNED_EN: when defined, operands are two's complement. The core
// divides magnitudes, the quotient truncates toward zero, and the remainder takes the sign of
// the dividend. When the macro is undefined, no sign logic is built.
module seq_divider16 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 div_by_zero,
    output logic                 overflow
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e              state_q;
    logic [CntW-1:0]     count_q;
    logic [WIDTH-1:0]    rem_q;       // partial remainder, always < divisor between steps
    logic [WIDTH-1:0]    dvd_q;       // low dividend half, shifted out MSB first
    logic [WIDTH-1:0]    dvs_q;
    logic [WIDTH-1:0]    quo_q;
    logic                busy_q, done_q, dbz_q, ovf_q;
    logic [WIDTH-1:0]    quotient_q, remainder_q;
`ifdef DIV_SIGNED_EN
    logic                dd_neg_q, dv_neg_q;
    logic                dd_neg, dv_neg, q_neg;
    logic [WIDTH-1:0]    ovf_limit;
`endif

    // Operand magnitudes, used by the pre-check and loaded into the core.
    logic [2*WIDTH-1:0]  dd_mag;
    logic [WIDTH-1:0]    dv_mag;
    logic                dbz_chk, ovf_chk;

    // One restoring step, plus the sign-corrected results that the last step publishes.
    logic [WIDTH:0]      rem_shift;
    logic                qbit;
    logic [WIDTH-1:0]    rem_d, quo_d;
    logic [WIDTH-1:0]    q_fin, r_fin;
    logic                ovf_fin;

    always_comb begin
`ifdef DIV_SIGNED_EN
        dd_neg = dividend[2*WIDTH-1];
        dv_neg = divisor[WIDTH-1];
        dd_mag = dd_neg ? -dividend : dividend;
        dv_mag = dv_neg ? -divisor : divisor;
`else
        dd_mag = dividend;
        dv_mag = divisor;
`endif
        dbz_chk = (divisor == '0);
        // The quotient fits in WIDTH bits only if the upper dividend half is below the divisor.
        ovf_chk = (dd_mag[2*WIDTH-1:WIDTH] >= dv_mag);
    end

    always_comb begin
        rem_shift = {rem_q, dvd_q[WIDTH-1]};
        qbit      = (rem_shift >= {1'b0, dvs_q});
        // The difference is below the divisor, so the low WIDTH bits of the subtraction are exact.
        rem_d     = qbit ? (rem_shift[WIDTH-1:0] - dvs_q) : rem_shift[WIDTH-1:0];
        quo_d     = {quo_q[WIDTH-2:0], qbit};
`ifdef DIV_SIGNED_EN
        q_neg     = dd_neg_q ^ dv_neg_q;
        q_fin     = q_neg ? -quo_d : quo_d;
        r_fin     = dd_neg_q ? -rem_d : rem_d;
        // A negative result can reach -2^(W-1). A positive result can reach only 2^(W-1)-1.
        ovf_limit = q_neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        ovf_fin   = (quo_d > ovf_limit);
`else
        q_fin     = quo_d;
        r_fin     = rem_d;
        ovf_fin   = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            count_q     <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            quo_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
`ifdef DIV_SIGNED_EN
            dd_neg_q    <= 1'b0;
            dv_neg_q    <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (start) begin
                        busy_q  <= 1'b1;
                        count_q <= CntW'(WIDTH);
                        rem_q   <= dd_mag[2*WIDTH-1:WIDTH];
                        dvd_q   <= dd_mag[WIDTH-1:0];
                        dvs_q   <= dv_mag;
                        quo_q   <= '0;
`ifdef DIV_SIGNED_EN
                        dd_neg_q <= dd_neg;
                        dv_neg_q <= dv_neg;
`endif
                        if (dbz_chk) begin
                            state_q     <= StDone;
                            done_q      <= 1'b1;
                            quotient_q  <= '1;
                            remainder_q <= dividend[WIDTH-1:0];
                            dbz_q       <= 1'b1;
                            ovf_q       <= 1'b0;
                        end else if (ovf_chk) begin
                            state_q     <= StDone;
                            done_q      <= 1'b1;
                            quotient_q  <= '1;
                            remainder_q <= '0;
                            dbz_q       <= 1'b0;
                            ovf_q       <= 1'b1;
                        end else begin
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    rem_q   <= rem_d;
                    quo_q   <= quo_d;
                    dvd_q   <= {dvd_q[WIDTH-2:0], 1'b0};
                    count_q <= count_q - CntW'(1);
                    if (count_q == CntW'(1)) begin
                        state_q     <= StDone;
                        done_q      <= 1'b1;
                        quotient_q  <= q_fin;
                        remainder_q <= r_fin;
                        dbz_q       <= 1'b0;
                        ovf_q       <= ovf_fin;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_seq_divider16.sv
// tb_seq_divider16: self-checking bench for seq_divider16.
// A transaction-level model computes each result with plain integer division. It also tracks
// how many cycles the divider remains busy, and the outputs are checked against it on every
// falling edge. Directed operations pin the expected values and latencies with literals.
module tb_seq_divider16;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [31:0]   dividend = '0;
    logic [15:0]   divisor = '0;
    logic          busy, done, div_by_zero, overflow;
    logic [15:0]   quotient, remainder;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seq_divider16 #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference division from the arithmetic rules; 'early' marks a request that skips the run.
    function automatic void ref_div(input logic [31:0] dd, input logic [15:0] dv,
                                    output logic [15:0] q, output logic [15:0] r,
                                    output logic dbz, output logic ovf, output logic early);
`ifdef DIV_SIGNED_EN
        longint sdd, sdv, mdd, mdv, mq, mr, qv, rv;
        logic   neg;
        sdd = longint'($signed(dd));
        sdv = longint'($signed(dv));
        mdd = (sdd < 0) ? -sdd : sdd;
        mdv = (sdv < 0) ? -sdv : sdv;
`else
        longint mdd, mdv, mq, mr;
        mdd = longint'(dd);
        mdv = longint'(dv);
`endif
        dbz = 1'b0; ovf = 1'b0; early = 1'b0; q = 16'hFFFF; r = 16'h0000;
        if (mdv == 0) begin
            dbz = 1'b1; early = 1'b1; r = dd[15:0];
            return;
        end
        mq = mdd / mdv;
        mr = mdd % mdv;
        if (mq > 65535) begin
            ovf = 1'b1; early = 1'b1;
            return;
        end
`ifdef DIV_SIGNED_EN
        neg = (sdd < 0) != (sdv < 0);
        qv  = neg ? -mq : mq;
        rv  = (sdd < 0) ? -mr : mr;
        q   = qv[15:0];
        r   = rv[15:0];
        ovf = mq > (neg ? 64'sd32768 : 64'sd32767);
`else
        q = mq[15:0];
        r = mr[15:0];
`endif
    endfunction

    // Model state: cycles of busy remaining (1 = done cycle), pending and visible results.
    int          m_left = 0;
    logic [15:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
    logic        m_dbz = 1'b0, m_ovf = 1'b0, p_dbz = 1'b0, p_ovf = 1'b0, p_early = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left = 0;
            m_q = '0; m_r = '0; m_dbz = 1'b0; m_ovf = 1'b0;
        end else begin
            if (m_left == 0) begin
                if (start) begin
                    ref_div(dividend, divisor, p_q, p_r, p_dbz, p_ovf, p_early);
                    m_left = p_early ? 1 : W + 1;
                end
            end else begin
                m_left--;
            end
            if (m_left == 1) begin
                m_q = p_q; m_r = p_r; m_dbz = p_dbz; m_ovf = p_ovf;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(m_left != 0));
        chk("done", 32'(done), 32'(m_left == 1));
        chk("quotient", 32'(quotient), 32'(m_q));
        chk("remainder", 32'(remainder), 32'(m_r));
        chk("div_by_zero", 32'(div_by_zero), 32'(m_dbz));
        chk("overflow", 32'(overflow), 32'(m_ovf));
    end

    // Issue one request, optionally poke start at two RUN cycles, and check literal results.
    task automatic op(input string name, input logic [31:0] dd, input logic [15:0] dv,
                      input logic [15:0] eq, input logic [15:0] er, input logic edbz,
                      input logic eovf, input int elat, input int poke_a, input int poke_b);
        int   k;
        logic seen;
        k = 0;
        seen = 1'b0;
        @(negedge clk); #1;
        start = 1'b1; dividend = dd; divisor = dv;
        do begin
            @(negedge clk);
            k++;
            seen = done;
            #1;
            start = (k == poke_a) || (k == poke_b);
            if (start) begin
                dividend = $urandom;
                divisor  = 16'($urandom);
            end
        end while (!seen && k < 40);
        start = 1'b0;
        chk({name, " done seen"}, 32'(seen), 32'd1);
        chk({name, " latency"}, k, elat);
        chk({name, " q"}, 32'(quotient), 32'(eq));
        chk({name, " r"}, 32'(remainder), 32'(er));
        chk({name, " dbz"}, 32'(div_by_zero), 32'(edbz));
        chk({name, " ovf"}, 32'(overflow), 32'(eovf));
    endtask

    initial begin
        logic [15:0] dv;
        logic [15:0] hi;
        int          k;

        repeat (2) @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset q", 32'(quotient), 32'd0);
        #1 rst = 1'b0;

        op("t1", 32'h0001_0000, 16'h0100, 16'h0100, 16'h0000, 1'b0, 1'b0, 17, 0, 0);
`ifndef DIV_SIGNED_EN
        op("t2a", 32'hFFFE_0001, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 17, 0, 0);
`endif
        op("t2b", 32'h0000_0007, 16'h0002, 16'h0003, 16'h0001, 1'b0, 1'b0, 17, 0, 0);
        op("t3", 32'h1234_5678, 16'h0000, 16'hFFFF, 16'h5678, 1'b1, 1'b0, 1, 0, 0);
        op("t4", 32'h0001_0000, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1, 0, 0);
        op("t5 busy start", 32'h0001_0000, 16'h0100, 16'h0100, 16'h0000, 1'b0, 1'b0, 17, 3, 8);
`ifdef DIV_SIGNED_EN
        op("t6", 32'hFFFF_FFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0, 17, 0, 0);
`else
        op("t6", 32'hFFFF_FFF9, 16'h0002, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1, 0, 0);
`endif

        // Reset at RUN cycle 5 clears everything; the next request then runs cleanly.
        @(negedge clk); #1;
        start = 1'b1; dividend = 32'h0000_0007; divisor = 16'h0002;
        @(negedge clk); #1 start = 1'b0;
        repeat (4) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst q", 32'(quotient), 32'd0);
        chk("rst r", 32'(remainder), 32'd0);
        chk("rst flags", 32'({div_by_zero, overflow}), 32'd0);
        @(negedge clk); #1 rst = 1'b0;
        op("t5 after rst", 32'h0001_0000, 16'h0100, 16'h0100, 16'h0000, 1'b0, 1'b0, 17, 0, 0);

        // Random traffic: start is sometimes held high while busy, with rare mid-flight resets.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            k  = $urandom_range(0, 9);
            dv = 16'($urandom);
            if (k == 0) dv = 16'h0000;
            else if (dv == 16'h0000) dv = 16'h0001;
            hi = (k <= 1) ? 16'($urandom) : 16'($urandom % dv);
            dividend = {hi, 16'($urandom)};
            divisor  = dv;
            start    = ($urandom_range(0, 3) == 0);
            rst      = ($urandom_range(0, 499) == 0);
        end
        @(negedge clk); #1;
        start = 1'b0;
        rst   = 1'b0;
        repeat (25) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
